// File: rtl/imem_load_ctrl_if.sv
// Bundles the CPU fetch, instruction-memory and loader signals of imem_load_ctrl.
// slave: controller view; master: CPU/array/loader environment view.
// No storage; all signals are plain wires.
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_instr;
    logic              cpu_stall;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    logic              ld_start;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              ld_abort;
    logic              ld_done;
    logic              ld_err;

    modport slave (
        input  cpu_addr, mem_rdata, ld_start, ld_count, ld_valid, ld_data, ld_abort,
        output cpu_instr, cpu_stall, mem_addr, mem_wdata, mem_we, ld_ready, ld_done, ld_err
    );

    modport master (
        output cpu_addr, mem_rdata, ld_start, ld_count, ld_valid, ld_data, ld_abort,
        input  cpu_instr, cpu_stall, mem_addr, mem_wdata, mem_we, ld_ready, ld_done, ld_err
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Arbitrates the instruction-memory port between CPU fetch and a clear-then-load program loader.
// Latency: fetch is combinational (zero cycles); clear takes DEPTH cycles, one loader word per cycle.
// Backpressure: ld_ready is high only while loading; the CPU is stalled whenever it lacks the port.
module imem_load_ctrl #(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    imem_load_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              r_load_pend;
    logic              w_load_pend_nxt;
    logic              r_done;
    logic              r_err;
    logic              w_err_evt;
    logic              w_accept;
    logic              w_last_clr;
    logic              w_last_wr;
    logic              w_cnt_legal;
    logic              w_unused_addr_bits;

    assign w_last_clr  = (r_clr_ptr == LAST_ADDR);
    assign w_last_wr   = ({1'b0, r_wr_ptr} == (r_cnt - CNT_ONE));
    assign w_cnt_legal = (bus.ld_count != '0) && (bus.ld_count <= CNT_MAX);

    // Byte offset and high address bits are dropped so fetches wrap over the array.
    assign w_unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_ptr_nxt   = r_clr_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_cnt_nxt       = r_cnt;
        w_load_pend_nxt = r_load_pend;
        w_err_evt       = 1'b0;
        w_accept        = 1'b0;

        bus.cpu_stall   = 1'b1;
        bus.cpu_instr   = NOP_WORD;
        bus.mem_addr    = r_wr_ptr;
        bus.mem_wdata   = NOP_WORD;
        bus.mem_we      = 1'b0;
        bus.ld_ready    = 1'b0;

        case (r_state)
            S_CLEAR: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = r_clr_ptr;
                if (bus.ld_abort) begin
                    w_state_nxt     = S_RUN;
                    w_err_evt       = 1'b1;
                    w_load_pend_nxt = 1'b0;
                    w_clr_ptr_nxt   = '0;
                    w_wr_ptr_nxt    = '0;
                end else if (w_last_clr) begin
                    w_state_nxt   = r_load_pend ? S_LOAD : S_RUN;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + PTR_ONE;
                end
            end

            S_LOAD: begin
                bus.ld_ready = 1'b1;
                w_accept     = bus.ld_valid;
                if (w_accept) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.ld_data;
                    w_wr_ptr_nxt  = r_wr_ptr + PTR_ONE;
                end
                // Abort outranks completion; the word written this cycle still lands.
                if (bus.ld_abort) begin
                    w_state_nxt     = S_RUN;
                    w_err_evt       = 1'b1;
                    w_load_pend_nxt = 1'b0;
                    w_clr_ptr_nxt   = '0;
                    w_wr_ptr_nxt    = '0;
                end else if (w_accept && w_last_wr) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_load_pend_nxt = 1'b0;
                w_wr_ptr_nxt    = '0;
                w_state_nxt     = S_RUN;
            end

            S_RUN: begin
                bus.cpu_stall = 1'b0;
                bus.mem_addr  = bus.cpu_addr[ADDR_W+1:2];
                bus.cpu_instr = bus.mem_rdata;
                if (bus.ld_start) begin
                    if (w_cnt_legal) begin
                        w_cnt_nxt       = bus.ld_count;
                        w_load_pend_nxt = 1'b1;
                        w_state_nxt     = S_CLEAR;
                    end else begin
                        w_err_evt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_clr_ptr   <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_load_pend <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_ptr   <= w_clr_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_load_pend <= w_load_pend_nxt;
            r_done      <= (w_state_nxt == S_DONE);
            r_err       <= w_err_evt;
        end
    end

    assign bus.ld_done = r_done;
    assign bus.ld_err  = r_err;

    a_no_write_in_run: assert property (@(posedge clk) disable iff (rst)
        (r_state == S_RUN) |-> !bus.mem_we);
    a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
        bus.ld_done |=> !bus.ld_done);
    a_ready_only_in_load: assert property (@(posedge clk) disable iff (rst)
        bus.ld_ready |-> (r_state == S_LOAD));

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: models the array, scoreboards every write,
// and checks fetch results, stall timing and done/err pulses per scenario.
module tb_imem_load_ctrl;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic fill;

    always #5 clk = ~clk;

    imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_load_ctrl #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] wrds [8];
    wr_t         exp_q [$];

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    int n_err = 0;
    int n_we = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | i;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rst) begin
            if (bus.ld_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.ld_err) n_err++;
            if (bus.mem_we) begin
                n_we++;
                last_we_cyc = cyc;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL write_sb: unexpected write addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_wdata} !== e)
                        $display("FAIL write_sb: got addr=%0d data=%h, want addr=%0d data=%h",
                                 bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int a = 0; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), 32'h0});
    endtask

    task automatic push_words(input int n);
        for (int a = 0; a < n; a++) exp_q.push_back({ADDR_W'(a), wrds[a]});
    endtask

    task automatic wait_run(output int stall_cycles);
        stall_cycles = 0;
        @(negedge clk);
        while (bus.cpu_stall && stall_cycles < 1000) begin
            stall_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        tick();
        bus.cpu_addr = a;
        @(negedge clk);
    endtask

    task automatic start_load(input logic [ADDR_W:0] cnt);
        tick();
        bus.ld_start = 1'b1;
        bus.ld_count = cnt;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] pat, input int plen, input int nw);
        int idx = 0;
        int k = 0;
        int guard = 0;
        while (idx < nw && guard < 2000) begin
            bus.ld_valid = pat[k % plen];
            bus.ld_data  = wrds[idx];
            @(negedge clk);
            if (bus.ld_ready) begin
                if (bus.ld_valid) idx++;
                k++;
            end
            guard++;
            tick();
        end
        bus.ld_valid = 1'b0;
        n_total++;
        if (idx !== nw) $display("FAIL feed_timeout: accepted %0d words, want %0d", idx, nw);
        else n_pass++;
    endtask

    task automatic test_reset();
        int sc;
        rst = 1'b1;
        fill = 1'b1;
        repeat (2) @(posedge clk);
        #1 fill = 1'b0;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b1) $display("FAIL rst_stall: got %b want 1", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.ld_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ld_ready); else n_pass++;
        n_total++; if (bus.cpu_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", bus.cpu_instr); else n_pass++;
        push_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_run(sc);
        n_total++; if (sc !== 64) $display("FAIL rst_clear_len: got %0d stall cycles want 64", sc); else n_pass++;
        fetch(32'h10);
        n_total++; if (bus.cpu_instr !== 32'h0) $display("FAIL rst_fetch10: got %h want 0", bus.cpu_instr); else n_pass++;
        n_total++; if (bus.mem_addr !== 6'd4) $display("FAIL rst_fetch_addr: got %0d want 4", bus.mem_addr); else n_pass++;
    endtask

    task automatic test_load_basic();
        int sc;
        int d0;
        logic [31:0] want [4];
        wrds[0] = 32'h1111_AAAA; wrds[1] = 32'h2222_BBBB; wrds[2] = 32'h3333_CCCC;
        want[0] = wrds[0]; want[1] = wrds[1]; want[2] = wrds[2]; want[3] = 32'h0;
        push_clear();
        push_words(3);
        d0 = n_done;
        start_load(7'd3);
        feed(16'h1, 1, 3);
        wait_run(sc);
        n_total++; if (sc !== 1) $display("FAIL basic_done_len: got %0d stall cycles after last word want 1", sc); else n_pass++;
        n_total++; if (n_done - d0 !== 1) $display("FAIL basic_done_cnt: got %0d pulses want 1", n_done - d0); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            n_total++;
            if (bus.cpu_instr !== want[i]) $display("FAIL basic_fetch%0d: got %h want %h", i, bus.cpu_instr, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bad_count();
        logic [ADDR_W:0] bad [2];
        int w0, e0, s;
        bad[0] = 7'd0;
        bad[1] = 7'd65;
        for (int b = 0; b < 2; b++) begin
            w0 = n_we;
            e0 = n_err;
            s = 0;
            start_load(bad[b]);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.cpu_stall) s++;
            end
            n_total++; if (n_err - e0 !== 1) $display("FAIL bad%0d_err: got %0d pulses want 1", bad[b], n_err - e0); else n_pass++;
            n_total++; if (s !== 0) $display("FAIL bad%0d_stall: got %0d stall cycles want 0", bad[b], s); else n_pass++;
            n_total++; if (n_we - w0 !== 0) $display("FAIL bad%0d_we: got %0d writes want 0", bad[b], n_we - w0); else n_pass++;
        end
    endtask

    task automatic test_gaps();
        int sc, d0;
        wrds[0] = 32'hC0DE_0000; wrds[1] = 32'hC0DE_0001; wrds[2] = 32'hC0DE_0002; wrds[3] = 32'hC0DE_0003;
        push_clear();
        push_words(4);
        d0 = n_done;
        start_load(7'd4);
        feed(16'b1011001, 7, 4);
        wait_run(sc);
        n_total++; if (n_done - d0 !== 1) $display("FAIL gaps_done_cnt: got %0d want 1", n_done - d0); else n_pass++;
        n_total++; if (done_cyc !== last_we_cyc + 1)
            $display("FAIL gaps_done_timing: done at cycle %0d, want %0d", done_cyc, last_we_cyc + 1);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            n_total++;
            if (bus.cpu_instr !== wrds[i]) $display("FAIL gaps_fetch%0d: got %h want %h", i, bus.cpu_instr, wrds[i]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int d0;
        logic [31:0] want;
        for (int i = 0; i < 5; i++) wrds[i] = 32'hBEEF_0100 + 32'(i);
        push_clear();
        push_words(2);
        d0 = n_done;
        start_load(7'd5);
        feed(16'h1, 1, 2);
        bus.ld_abort = 1'b1;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b1) $display("FAIL abort_cycle_stall: got %b want 1", bus.cpu_stall); else n_pass++;
        tick();
        bus.ld_abort = 1'b0;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL abort_run: stall got %b want 0", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.ld_err !== 1'b1) $display("FAIL abort_err: got %b want 1", bus.ld_err); else n_pass++;
        n_total++; if (n_done - d0 !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", n_done - d0); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < 2) ? wrds[i] : 32'h0;
            fetch(32'(i * 4));
            n_total++;
            if (bus.cpu_instr !== want) $display("FAIL abort_mem%0d: got %h want %h", i, bus.cpu_instr, want);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_and_start_ignored();
        int sc, d0, e0, g;
        fetch(32'h104);
        n_total++; if (bus.mem_addr !== 6'd1) $display("FAIL wrap_104_addr: got %0d want 1", bus.mem_addr); else n_pass++;
        n_total++; if (bus.cpu_instr !== 32'hBEEF_0101) $display("FAIL wrap_104_instr: got %h want beef0101", bus.cpu_instr); else n_pass++;
        fetch(32'h107);
        n_total++; if (bus.mem_addr !== 6'd1) $display("FAIL wrap_107_addr: got %0d want 1", bus.mem_addr); else n_pass++;

        wrds[0] = 32'h5A5A_0000; wrds[1] = 32'h5A5A_0001;
        push_clear();
        push_words(2);
        d0 = n_done;
        e0 = n_err;
        start_load(7'd2);
        g = 0;
        @(negedge clk);
        while (!bus.ld_ready && g < 200) begin
            g++;
            @(negedge clk);
        end
        tick();
        bus.ld_start = 1'b1; bus.ld_count = 7'd0;
        tick();
        bus.ld_count = 7'd5;
        tick();
        bus.ld_start = 1'b0;
        feed(16'h1, 1, 2);
        wait_run(sc);
        n_total++; if (n_done - d0 !== 1) $display("FAIL ign_done: got %0d pulses want 1", n_done - d0); else n_pass++;
        n_total++; if (n_err - e0 !== 0) $display("FAIL ign_err: got %0d pulses want 0", n_err - e0); else n_pass++;
        fetch(32'h4);
        n_total++; if (bus.cpu_instr !== 32'h5A5A_0001) $display("FAIL ign_fetch1: got %h want 5a5a0001", bus.cpu_instr); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        fill = 1'b0;
        bus.cpu_addr = '0;
        bus.ld_start = 1'b0;
        bus.ld_count = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data = '0;
        bus.ld_abort = 1'b0;

        test_reset();
        test_load_basic();
        test_bad_count();
        test_gaps();
        test_abort();
        test_wrap_and_start_ignored();

        repeat (2) @(negedge clk);
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d expected writes never seen", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
